// File: rtl/pipe_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_ctrl
// Brief    : DEPTH-stage payload pipeline with stall, flush, bubble collapse,
//            valid/ready ends, occupancy and saturating flushed-entry count.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [DEPTH-1:0]           stall_req,
    input  logic [DEPTH-1:0]           flush_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [DEPTH*WIDTH-1:0]     stage_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           flushed_cnt
);

    localparam int              c_occW   = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] c_cntMax = '1;

    logic [DEPTH-1:0]       r_valid;
    logic [WIDTH-1:0]       r_data [DEPTH];
    logic [c_occW-1:0]      r_occupancy;
    logic [CNT_W-1:0]       r_flushedCnt;

    logic [DEPTH-1:0]       w_fl;
    logic [DEPTH-1:0]       w_hold;
    logic [DEPTH-1:0]       w_nextValid;
    logic [DEPTH-1:0]       w_load;
    logic [WIDTH-1:0]       w_src [DEPTH];
    logic                   w_inReady;
    logic [c_occW-1:0]      w_flushPop;
    logic [CNT_W+c_occW-1:0] w_cntSum;

    function automatic logic [c_occW-1:0] popCount(input logic [DEPTH-1:0] bits);
        logic [c_occW-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + c_occW'(bits[i]);
        end
        return n;
    endfunction

    // Flush coverage and hold both propagate from the oldest stage downwards.
    always_comb begin
        w_fl   = '0;
        w_hold = '0;
        w_fl[DEPTH-1]   = flush_req[DEPTH-1];
        w_hold[DEPTH-1] = r_valid[DEPTH-1] & (stall_req[DEPTH-1] | ~out_ready);
        for (int i = DEPTH-2; i >= 0; i--) begin
            w_fl[i]   = w_fl[i+1] | flush_req[i];
            w_hold[i] = r_valid[i] & (stall_req[i] | w_hold[i+1]);
        end
    end

    assign w_inReady = ~w_hold[0] & ~(|flush_req);

    always_comb begin
        w_nextValid = '0;
        w_load      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_fl[i]) begin
                w_nextValid[i] = 1'b0;
            end else if (w_hold[i]) begin
                w_nextValid[i] = 1'b1;
            end else if (i == 0) begin
                w_nextValid[i] = in_valid & w_inReady;
                w_load[i]      = in_valid & w_inReady;
            end else begin
                w_nextValid[i] = r_valid[i-1] & ~w_hold[i-1] & ~w_fl[i-1];
                w_load[i]      = r_valid[i-1] & ~w_hold[i-1] & ~w_fl[i-1];
            end
        end
    end

    assign w_flushPop = popCount(r_valid & w_fl);
    assign w_cntSum   = {{c_occW{1'b0}}, r_flushedCnt} + {{CNT_W{1'b0}}, w_flushPop};

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= '0;
            r_occupancy  <= '0;
            r_flushedCnt <= '0;
        end else begin
            r_valid     <= w_nextValid;
            r_occupancy <= popCount(w_nextValid);
            if (|w_cntSum[CNT_W+c_occW-1:CNT_W]) begin
                r_flushedCnt <= c_cntMax;
            end else begin
                r_flushedCnt <= w_cntSum[CNT_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_src[gi] = in_data;
            end else begin : g_body
                assign w_src[gi] = r_data[gi-1];
            end

            // Payload is only written when a new item arrives; bubbles keep stale data.
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    r_data[gi] <= '0;
                end else if (w_load[gi]) begin
                    r_data[gi] <= w_src[gi];
                end
            end

            assign stage_data[gi*WIDTH +: WIDTH] = r_data[gi];
        end
    endgenerate

    assign in_ready    = w_inReady;
    assign out_valid   = r_valid[DEPTH-1] & ~stall_req[DEPTH-1] & ~w_fl[DEPTH-1];
    assign out_data    = r_data[DEPTH-1];
    assign stage_valid = r_valid;
    assign occupancy   = r_occupancy;
    assign flushed_cnt = r_flushedCnt;

endmodule
`default_nettype wire

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
- Parametrised replacement for the hand-written IF/ID/EX/MEM/WB register banks.
- Chain of DEPTH pipeline stages of WIDTH-bit payload, each with its own valid bit.
- Adds per-stage stall, per-stage flush, bubble collapse, valid/ready handshakes at both ends, an occupancy count and a saturating flushed-entry counter.
- The CPU top instantiates one per payload bundle: instruction, control and data fields are packed into in_data.

Parameters:
WIDTH, 32, payload bits per stage
DEPTH, 4, number of stages (>=2); stage 0 is youngest (input side), stage DEPTH-1 is oldest (output side)
CNT_W, 16, width of flushed_cnt

Ports:
clk  input  1  pipeline clock; all state updates on the falling edge, matching the rest of the pipeline
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream offers in_data
in_ready  output  1  stage 0 accepts this cycle
in_data  input  WIDTH  payload entering stage 0
stall_req  input  DEPTH  bit i: stage i must keep its contents this cycle
flush_req  input  DEPTH  bit k: invalidate stages 0..k this cycle
out_valid  output  1  stage DEPTH-1 presents a deliverable item
out_ready  input  1  downstream consumes out_data
out_data  output  WIDTH  payload of stage DEPTH-1
stage_valid  output  DEPTH  registered valid bit of every stage
stage_data  output  DEPTH*WIDTH  stage i payload at bits [i*WIDTH +: WIDTH]
occupancy  output  $clog2(DEPTH+1)  registered count of valid stages
flushed_cnt  output  CNT_W  saturating count of valid entries destroyed by flush

Behaviour:
- Reset (async, any time, including mid-transfer):
  - All valid bits, stage data, occupancy and flushed_cnt go to 0 immediately.
  - Consequently out_valid=0 and in_ready=1 while rst is high.
  - The first update after rst falls occurs on the next falling clk edge.
- Flush coverage: fl[i] = OR of flush_req[k] for k>=i. Any flush_req bit set forces in_ready=0, and in_data is dropped that cycle.
- Hold, combinational, evaluated from stage DEPTH-1 down to stage 0:
  - hold[DEPTH-1] = v[DEPTH-1] & (stall_req[DEPTH-1] | ~out_ready)
  - hold[i] = v[i] & (stall_req[i] | hold[i+1])
  - An invalid stage never holds, so bubbles collapse and a younger item fills a hole the same cycle.
- out_valid = v[DEPTH-1] & ~stall_req[DEPTH-1] & ~fl[DEPTH-1]. A transfer occurs when out_valid & out_ready.
- in_ready = ~hold[0] & ~(|flush_req).
- Next state, per stage, in priority order:
  - fl[i]: v[i] <= 0. Flush beats hold and load.
  - else hold[i]: v[i] and data[i] are unchanged.
  - else stage 0: v[0] <= in_valid & in_ready.
  - else stage i>0: v[i] <= v[i-1] & ~hold[i-1] & ~fl[i-1].
- Data register loads only when its new valid bit is 1. Otherwise it keeps its old value; it is not cleared.
- Latency: an item accepted at edge n appears at out_data after edge n+DEPTH-1, assuming no stalls. It therefore occupies DEPTH cycles. Throughput is one item per cycle.
- Ordering: items never reorder, duplicate or vanish, except by flush.
- occupancy <= popcount of next v.
- flushed_cnt:
  - Adds the popcount of (v & fl) each edge and saturates at 2^CNT_W-1; it never wraps.
  - An item leaving via out_valid&out_ready in the same cycle cannot be flushed, because out_valid is already gated by fl.
- Full condition: all v=1 and out_ready=0 gives in_ready=0. Sustained input at full throughput is possible with out_ready=1 and no stalls.

Test Plan:
- Reset: load 3 items, assert rst asynchronously between edges → stage_valid=0, occupancy=0, out_valid=0 and in_ready=1 at once; after release, item 0x55 accepted and emerges 4 cycles later.
- Streaming (DEPTH=4): in_data 1..8 on consecutive cycles, out_ready=1 → out_data 1..8 back-to-back, first valid 4 cycles after acceptance of 1; occupancy steady at 4.
- Backpressure: out_ready=0 while feeding 0xA0..0xA5 → 0xA0..0xA3 captured, in_ready=0, occupancy=4; raise out_ready → 0xA0..0xA5 delivered in order, no duplicates.
- Bubble collapse: stall_req[1]=1 for 3 cycles mid-stream → stage 2 receives bubbles; stage 0 holds only while stage 1 is valid; after release, no item is lost and holes ahead of stage 1 close as items advance.
- Flush: all 4 valid (0x10..0x13, oldest 0x13), flush_req=4'b0100 with in_valid=1 → stages 0..2 invalid next edge, in_data dropped, 0x13 still delivered, flushed_cnt=3.
- Flush vs output: stage 3 valid, out_ready=1, flush_req[3]=1 → out_valid=0 that cycle, no transfer, flushed_cnt+=1. Preload flushed_cnt near max → saturates at 0xFFFF.
